tl_arb_mux: RTL and testbench
=============================

Name: tl_arb_mux

Overview:
- N-to-1 arbitrating multiplexer for one TileLink channel in the crossbar. It is the converging counterpart of the crossbar's 1-to-N select-steered fan-out.
- Merges N source ports onto one sink port using round-robin arbitration.
- Holds the grant for the whole multi-beat message, up to and including the beat marked last.
- Registers the output (one pipeline stage) and reports the winning port index on sel_o, so the response path can steer back.

Parameters:
- N, 4, number of source ports (2..16).
- DATA_W, 64, width of the packed channel payload per port.
- SEL_W, 2, width of the port index; must satisfy 2**SEL_W >= N.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  N  per-source beat valid.
- ready_o  output  N  per-source beat accept.
- data_i  input  N*DATA_W  per-source payload; port i occupies bits [i*DATA_W +: DATA_W].
- last_i  input  N  per-source final-beat-of-message flag.
- valid_o  output  1  registered beat valid to sink.
- ready_i  input  1  sink accept.
- data_o  output  DATA_W  registered payload.
- last_o  output  1  registered last flag.
- sel_o  output  SEL_W  index of the source that produced the current output beat.

Behaviour:
- Interface: clk_i / rst_ni, single clock domain. Reset is asynchronous assert, active low, released synchronously by the upstream reset controller.
- Reset values: valid_o=0, data_o=0, last_o=0, sel_o=0, rr_ptr=0, locked=0, lock_idx=0.
- Handshake: a beat transfers when valid and ready are both high at a clock edge.
  - Sources hold valid_i, data_i and last_i stable until accepted.
  - The block holds valid_o, data_o, last_o and sel_o stable until ready_i.
- Output stage: load_en = !valid_o || ready_i.
  - ready_o[g] = load_en && grant[g]. At most one bit of ready_o is high in any cycle.
- Arbitration, unlocked:
  - grant goes to the first i with valid_i[i] set, scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
  - Grant is combinational and may change between cycles while load_en=0. No beat transfers in those cycles.
- Arbitration, locked: grant = one-hot(lock_idx) only. All other sources are ignored even if valid.
- On an accepted beat from port g:
  - Register data_i[g], last_i[g], and sel_o=g; set valid_o=1.
  - last_i[g]=0: locked=1, lock_idx=g.
  - last_i[g]=1: locked=0, rr_ptr=(g+1) mod N. rr_ptr wraps from N-1 to 0, including for non-power-of-2 N.
- rr_ptr advances only when a message completes, never on an intermediate beat.
- When load_en=1 and no source is granted: valid_o clears if ready_i=1; data_o, last_o and sel_o keep their previous values.
- Latency: 1 cycle from input acceptance to valid_o. Throughput: 1 beat per cycle, sustained with ready_i held high.
- Simultaneous events: the output drains and a new beat loads in the same cycle when valid_o && ready_i && a source is granted.
- Single-beat messages (last=1 on the first beat) never lock.
- sel_o is always < N.
- Reset mid-message: lock and pointer clear and valid_o drops immediately. The partial message is abandoned; upstream reset covers the sources.
- No out-of-range select exists. Unused index codes (N < 2**SEL_W) are never produced.

Decomposition:
- Shared package tl_xbar_pkg:
  - clog2-style sel-width function.
  - Localparams for default N, DATA_W, SEL_W, so tl_arb_mux and its fan-out counterpart agree on SEL_W.
- One sub-module, tl_rr_arb: combinational round-robin picker.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: grant[N] one-hot, gnt_idx[SEL_W], any_gnt.
  - Uses the masked-request / unmasked-fallback scheme.
- tl_arb_mux holds the lock state, the pointer and the output register.

Test Plan:
- Reset: drive rst_ni=0 mid-stream -> valid_o=0, sel_o=0, ready_o=0000 asynchronously. After release, the first grant goes to port 0 when all four sources are valid.
- Round-robin fairness: N=4, all ports hold single-beat (last=1) requests, ready_i=1 -> sel_o sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- Burst lock: port 2 sends 4 beats (last on beat 4) while ports 0, 1 and 3 are valid -> sel_o=2 for 4 consecutive beats, then 3, 0, 1. ready_o[0,1,3]=0 throughout the burst.
- Backpressure: ready_i=0 for 5 cycles with output full -> data_o, last_o and sel_o are stable and ready_o=0000. On ready_i=1, the next beat loads in the same cycle.
- Pointer wrap / non-power-of-2: N=3, SEL_W=2, only port 2 then port 0 requesting -> grants 2 then 0, and sel_o is never 3.
- Idle gaps: a single source sends beats with valid gaps and ready_i=1 -> valid_o drops in the gap cycles and the order of data_o is preserved.

Source files
------------

// File: rtl/tl_xbar_pkg.sv
// rtl/tl_xbar_pkg.sv - shared widths and helpers for the TileLink crossbar
package tl_xbar_pkg;

  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int TL_N      = 4;
  localparam int TL_DATA_W = 64;
  localparam int TL_SEL_W  = sel_width(TL_N);

endpackage

// File: rtl/tl_rr_arb.sv
// rtl/tl_rr_arb.sv - combinational round-robin picker
// Requests at or above ptr win first; if none, the lowest request overall wins.
module tl_rr_arb
  import tl_xbar_pkg::*;
#(
  parameter int N     = TL_N,
  parameter int SEL_W = TL_SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [N-1:0] masked;
  logic [N-1:0] cand;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) masked[i] = req[i] && (SEL_W'(i) >= ptr);
    cand = (|masked) ? masked : req;

    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !any_gnt) begin
        grant[i] = 1'b1;
        gnt_idx  = SEL_W'(i);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_arb_mux.sv
// rtl/tl_arb_mux.sv - N-to-1 round-robin arbitrating mux for one TileLink channel
// Grant is held across a multi-beat message; output is a single register stage.
module tl_arb_mux
  import tl_xbar_pkg::*;
#(
  parameter int N      = TL_N,
  parameter int DATA_W = TL_DATA_W,
  parameter int SEL_W  = TL_SEL_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N-1:0]        last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [SEL_W-1:0]    sel_o
);

  logic [N-1:0]      arb_req;
  logic [N-1:0]      grant;
  logic [N-1:0]      lock_mask;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  lock_idx;
  logic              any_gnt;
  logic              locked;
  logic              load_en;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  assign load_en = !valid_o || ready_i;

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < N; i++) lock_mask[i] = (SEL_W'(i) == lock_idx);
  end

  // While locked only the owning source can be granted, so the picker sees just that request.
  assign arb_req = locked ? (valid_i & lock_mask) : valid_i;

  tl_rr_arb #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign ready_o = {N{load_en && rst_ni}} & grant;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = data_i[i*DATA_W +: DATA_W];
        sel_last = last_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      data_o   <= '0;
      last_o   <= 1'b0;
      sel_o    <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (load_en) begin
      if (any_gnt) begin
        valid_o <= 1'b1;
        data_o  <= sel_data;
        last_o  <= sel_last;
        sel_o   <= gnt_idx;
        if (sel_last) begin
          locked <= 1'b0;
          rr_ptr <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end else begin
          locked   <= 1'b1;
          lock_idx <= gnt_idx;
        end
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tl_arb_mux.sv
// tb/tb_tl_arb_mux.sv - randomized and directed bench for tl_arb_mux
module tb_tl_arb_mux;
  import tl_xbar_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    valid_i, ready_o, last_i;
  logic [N*DW-1:0] data_i;
  logic            valid_o, ready_i, last_o;
  logic [DW-1:0]   data_o;
  logic [SW-1:0]   sel_o;

  logic [2:0]      valid3, ready3, last3;
  logic [3*DW-1:0] data3;
  logic            valid_o3, ready_i3, last_o3;
  logic [DW-1:0]   data_o3;
  logic [SW-1:0]   sel_o3;

  tl_arb_mux #(.N(N), .DATA_W(DW), .SEL_W(SW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
    .sel_o(sel_o)
  );

  tl_arb_mux #(.N(3), .DATA_W(DW), .SEL_W(SW)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid3), .ready_o(ready3), .data_i(data3),
    .last_i(last3), .valid_o(valid_o3), .ready_i(ready_i3), .data_o(data_o3), .last_o(last_o3),
    .sel_o(sel_o3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Source agents: one pending beat per port, held until accepted
  bit            pres[N];
  logic [DW-1:0] cur_d[N];
  bit            cur_l[N];
  int            left[N];
  int            force_len[N];
  int            p_valid, p_ready, max_len;
  logic [N-1:0]  en_mask;

  // Reference model: pointer, lock owner and the expected output register
  int            m_ptr, m_lock_idx;
  bit            m_locked;
  bit            e_valid, e_last;
  logic [DW-1:0] e_data;
  int            e_sel;
  int            sel_log[$];

  function automatic int pick(input logic [N-1:0] v);
    if (m_locked) return v[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      valid_i[i]            = pres[i];
      data_i[i*DW +: DW]    = cur_d[i];
      last_i[i]             = cur_l[i];
    end
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && en_mask[i] && ($urandom_range(99) < p_valid)) begin
        if (left[i] == 0) left[i] = (force_len[i] > 0) ? force_len[i] : $urandom_range(max_len, 1);
        pres[i]  = 1'b1;
        cur_d[i] = {$urandom, $urandom};
        cur_l[i] = (left[i] == 1);
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0; left[i] = 0; cur_d[i] = '0; cur_l[i] = 1'b0;
    end
    m_ptr = 0; m_lock_idx = 0; m_locked = 1'b0;
    e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_sel = 0;
  endtask

  // Called just after a rising edge with inputs driven; ends just after the next one.
  task automatic step();
    int           w;
    logic [N-1:0] acc;
    bit           ld;
    @(negedge clk);
    ld  = !e_valid || ready_i;
    w   = pick(valid_i);
    acc = '0;
    if (ld && w >= 0) acc[w] = 1'b1;
    check_eq("accept", 64'(ready_o & valid_i), 64'(acc));
    @(posedge clk); #1;
    if (ld) begin
      if (w >= 0) begin
        e_valid = 1'b1; e_data = cur_d[w]; e_last = cur_l[w]; e_sel = w;
        if (cur_l[w]) begin m_locked = 1'b0; m_ptr = (w + 1) % N; end
        else begin m_locked = 1'b1; m_lock_idx = w; end
        pres[w] = 1'b0;
        left[w]--;
      end else begin
        e_valid = 1'b0;
      end
    end
    check_eq("valid_o", 64'(valid_o), 64'(e_valid));
    if (e_valid) begin
      check_eq("data_o", data_o, e_data);
      check_eq("last_o", 64'(last_o), 64'(e_last));
      check_eq("sel_o", 64'(sel_o), 64'(e_sel));
    end
    if (valid_o === 1'b1) sel_log.push_back(int'(sel_o));
    refill();
    ready_i = ($urandom_range(99) < p_ready);
    drive_inputs();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sel_log.delete();
    refill();
    drive_inputs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid_o", 64'(valid_o), 64'd0);
    check_eq("arst_sel_o", 64'(sel_o), 64'd0);
    check_eq("arst_ready_o", 64'(ready_o), 64'd0);
    check_eq("arst_valid_o3", 64'(valid_o3), 64'd0);
    clear_model();
    ready_i = 1'b1;
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int exp[]);
    check_eq({tag, "_len"}, 64'(sel_log.size() >= exp.size()), 64'd1);
    for (int k = 0; k < exp.size() && k < sel_log.size(); k++)
      check_eq(tag, 64'(sel_log[k]), 64'(exp[k]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_rr[]    = '{0, 1, 2, 3, 0, 1};
    int exp_burst[] = '{2, 2, 2, 2, 3, 0, 1};
    int exp3[]      = '{1, 2, 0, 1, 2, 0};

    rst_n = 1'b0; ready_i = 1'b1; valid_i = '0; last_i = '0; data_i = '0;
    valid3 = '0; last3 = '0; data3 = '0; ready_i3 = 1'b1;
    clear_model();
    for (int i = 0; i < N; i++) force_len[i] = 0;
    @(negedge clk);
    check_eq("rst_valid_o", 64'(valid_o), 64'd0);
    check_eq("rst_data_o", data_o, 64'd0);
    check_eq("rst_last_o", 64'(last_o), 64'd0);
    check_eq("rst_sel_o", 64'(sel_o), 64'd0);
    check_eq("rst_ready_o", 64'(ready_o), 64'd0);

    // Round-robin fairness with single-beat messages on every port
    p_valid = 100; p_ready = 100; max_len = 1; en_mask = '1;
    release_rst();
    repeat (6) step();
    check_seq("rr_seq", exp_rr);

    // Port 2 bursts four beats while the others wait
    do_reset();
    force_len = '{1, 1, 4, 1};
    en_mask = 4'b0100;
    release_rst();
    step();
    en_mask = '1;
    refill();
    drive_inputs();
    repeat (6) step();
    check_seq("burst_seq", exp_burst);

    // Sink backpressure with the output register full
    p_ready = 0; ready_i = 1'b0;
    repeat (5) step();
    p_ready = 100; ready_i = 1'b1;
    repeat (3) step();

    // Random traffic, including a reset in the middle of messages
    force_len = '{0, 0, 0, 0};
    p_valid = 60; p_ready = 70; max_len = 4;
    repeat (600) step();
    do_reset();
    release_rst();
    repeat (600) step();

    // Single source with valid gaps
    do_reset();
    en_mask = 4'b0001; p_valid = 40; p_ready = 100;
    release_rst();
    repeat (200) step();

    // Non-power-of-two instance: port 2 then port 0, then all three
    valid3 = 3'b100; last3 = 3'b111;
    data3 = {64'h0000_00C2, 64'h0000_00C1, 64'h0000_00C0};
    @(negedge clk);
    check_eq("n3_ready_p2", 64'(ready3), 64'b100);
    @(posedge clk); #1;
    check_eq("n3_valid", 64'(valid_o3), 64'd1);
    check_eq("n3_sel_p2", 64'(sel_o3), 64'd2);
    check_eq("n3_data_p2", data_o3, 64'h0000_00C2);
    valid3 = 3'b001;
    @(negedge clk);
    check_eq("n3_ready_p0", 64'(ready3), 64'b001);
    @(posedge clk); #1;
    check_eq("n3_sel_p0", 64'(sel_o3), 64'd0);
    check_eq("n3_data_p0", data_o3, 64'h0000_00C0);
    valid3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_eq("n3_rr_seq", 64'(sel_o3), 64'(exp3[k]));
    end
    valid3 = 3'b000;
    @(posedge clk); #1;
    check_eq("n3_idle_valid", 64'(valid_o3), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
